sgnj_issue_arbiter: RTL and testbench
=====================================

// Module: sgnj_issue_arbiter
// PURPOSE
//  Shares one registered sign-injection datapath between two requesters (e.g. two issue ports).
//  Round-robin arbitration, valid/ready handshake on every port.
//  Results are queued in a small in-order result FIFO with tag and source ID.
//  Sits between the issue stage and the DLFloat16 FPU writeback mux.
// PARAMETERS
//  TAG_W      4  width of requester tag carried with each op
//  OUT_DEPTH  2  result FIFO entries (>=2, power of two)
// PORTS
//  clk          in   1      single clock, rising edge
//  rst          in   1      asynchronous, active-high reset
//  req0_valid   in   1      requester 0 op valid
//  req0_ready   out  1      requester 0 op accepted this cycle (valid&ready)
//  req0_sel     in   2      op: 00 neg, 01 sgnj, 10 sgnjn, 11 sgnjx
//  req0_a       in   16     operand 1 (sign source)
//  req0_b       in   16     operand 2 (magnitude source)
//  req0_tag     in   TAG_W  opaque tag returned with result
//  req1_*       --   --     identical set for requester 1
//  res_valid    out  1      result FIFO head valid
//  res_ready    in   1      consumer accepts head
//  res_data     out  16     result
//  res_tag      out  TAG_W  tag of originating op
//  res_src      out  1      0 = requester 0, 1 = requester 1
//  busy         out  1      op in flight or FIFO non-empty
// BEHAVIOUR
//  - Reset: req*_ready=0, res_valid=0, res_data/tag/src=0, busy=0; FIFO and stage register emptied;
//    RR pointer last=1, so req0 wins first conflict. Reset mid-operation discards all in-flight results.
//  - Op encoding: 00 {~a[15],a[14:0]}; 01 {a[15],b[14:0]}; 10 {~a[15],b[14:0]}; 11 {a[15]^b[15],b[14:0]}.
//  - Credit: can_issue = (fifo_count + stage_valid) < OUT_DEPTH; a pop in the same cycle counts toward
//    can_issue (fifo_count - pop).
//  - Arbitration (combinational, from current inputs): if !can_issue, no grant.
//    Else one valid -> grant it; both valid -> grant != last; update last on grant. ready = grant.
//    readies are never both high. ready may depend on valid; a requester may not wait on ready to raise valid.
//  - Stage 1: on grant at edge k, result/tag/src registered; stage_valid=1 after k.
//  - Push: stage contents written to FIFO tail at edge k+1; res_valid visible after k+1
//    (min latency 2 edges). No bypass. A new grant may land in stage at k+1 (full throughput 1/cycle).
//  - FIFO: in-order; simultaneous push and pop allowed, including at full (pop frees slot for push).
//    Pointers wrap modulo OUT_DEPTH; count is log2(OUT_DEPTH)+1 bits.
//  - res_* held stable while res_valid & !res_ready.
//  - busy = stage_valid | (fifo_count != 0).
//  - Values are pass-through bit ops: no NaN/denorm handling, no exception flags.
// STRUCTURE
//  - Package sgnj_pkg: localparams SGNJ_NEG=2'b00, SGNJ_INJ=2'b01, SGNJ_INJN=2'b10, SGNJ_INJX=2'b11;
//    function sgnj_apply(sel,a,b) returning 16-bit result (shared with FPU decode).
//  - Sub-module sgnj_rr_arb2: 2-way round-robin with enable (can_issue), outputs gnt[1:0], holds last.
//  - Stage register, FIFO storage and credit counter live in top module.
// TESTING
//  1 req0 sel=00 a=16'h3C00 tag=3, res_ready=1 -> res_data=16'hBC00, tag=3, src=0, res_valid after 2nd edge.
//  2 req1 sel=11 a=16'h8000 b=16'hC000 -> 16'h4000; sel=10 a=16'h0000 b=16'h4200 -> 16'hC200.
//  3 both valid every cycle, res_ready=1 -> grants 0,1,0,1...; 1 result/cycle, src alternates.
//  4 res_ready=0, both valid -> exactly OUT_DEPTH accepts, then both ready=0; raise res_ready -> results
//    pop in accept order, issue resumes same cycle as first pop.
//  5 rst asserted with stage full and FIFO=1 -> all outputs 0 immediately; after release no stale result;
//    first conflict granted to req0.
//  6 random traffic + scoreboard: every accepted tag returned once, in order, data matches sgnj_apply.

Source files
------------

// File: rtl/sgnj_pkg.sv
// Shared sign-injection encodings and the bit-level result function.
// Used by the issue arbiter and by FPU decode.
package sgnj_pkg;

    localparam logic [1:0] SGNJ_NEG  = 2'b00;
    localparam logic [1:0] SGNJ_INJ  = 2'b01;
    localparam logic [1:0] SGNJ_INJN = 2'b10;
    localparam logic [1:0] SGNJ_INJX = 2'b11;

    // a is the sign source and b the magnitude source, except for NEG, which only uses a.
    function automatic logic [15:0] sgnj_apply(
        input logic [1:0]  sel,
        input logic [15:0] a,
        input logic [15:0] b
    );
        logic [15:0] r;
        case (sel)
            SGNJ_NEG:  r = {~a[15], a[14:0]};
            SGNJ_INJ:  r = {a[15], b[14:0]};
            SGNJ_INJN: r = {~a[15], b[14:0]};
            SGNJ_INJX: r = {a[15] ^ b[15], b[14:0]};
            default:   r = {~a[15], a[14:0]};
        endcase
        return r;
    endfunction

endpackage

// File: rtl/sgnj_rr_arb2.sv
// Two-way round-robin arbiter with an enable input.
// The winner of a conflict is the requester that was not granted last.
module sgnj_rr_arb2 (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [1:0] req,
    output logic [1:0] gnt
);

    logic last_r;

    // Grant decode from the current requests and the last winner.
    always_comb begin
        gnt = 2'b00;
        if (!en) begin
            gnt = 2'b00;
        end else if (req == 2'b11) begin
            gnt = last_r ? 2'b01 : 2'b10;
        end else if (req[0]) begin
            gnt = 2'b01;
        end else if (req[1]) begin
            gnt = 2'b10;
        end else begin
            gnt = 2'b00;
        end
    end

    // Remember the last winner; reset to 1 so requester 0 wins the first conflict.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_r <= 1'b1;
        end else if (gnt != 2'b00) begin
            last_r <= gnt[1];
        end else begin
            last_r <= last_r;
        end
    end

endmodule

// File: rtl/sgnj_issue_arbiter.sv
// Two requesters share one registered sign-injection stage.
// Results drain through an in-order FIFO that carries the tag and the source ID.
module sgnj_issue_arbiter
    import sgnj_pkg::*;
#(
    parameter int TAG_W     = 4,
    parameter int OUT_DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [1:0]       req0_sel,
    input  logic [15:0]      req0_a,
    input  logic [15:0]      req0_b,
    input  logic [TAG_W-1:0] req0_tag,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [1:0]       req1_sel,
    input  logic [15:0]      req1_a,
    input  logic [15:0]      req1_b,
    input  logic [TAG_W-1:0] req1_tag,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [15:0]      res_data,
    output logic [TAG_W-1:0] res_tag,
    output logic             res_src,
    output logic             busy
);

    localparam int PTR_W = (OUT_DEPTH > 1) ? $clog2(OUT_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(OUT_DEPTH);

    typedef struct packed {
        logic [15:0]      data;
        logic [TAG_W-1:0] tag;
        logic             src;
    } res_t;

    logic [1:0]       gnt_s;
    logic             pop_s;
    logic             can_issue_s;
    logic [CNT_W-1:0] level_s;
    res_t             op_s;
    res_t             head_s;

    res_t             stage_r;
    logic             stage_valid_r;
    res_t             mem_r [OUT_DEPTH];
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [CNT_W-1:0] count_r;

    // A pop in this cycle frees a slot, so it counts toward the credit check.
    assign pop_s       = (count_r != {CNT_W{1'b0}}) & res_ready;
    assign level_s     = count_r - {{(CNT_W-1){1'b0}}, pop_s} + {{(CNT_W-1){1'b0}}, stage_valid_r};
    assign can_issue_s = !rst && (level_s < DEPTH_C);

    sgnj_rr_arb2 u_arb (
        .clk (clk),
        .rst (rst),
        .en  (can_issue_s),
        .req ({req1_valid, req0_valid}),
        .gnt (gnt_s)
    );

    assign req0_ready = gnt_s[0];
    assign req1_ready = gnt_s[1];

    // Compute the result of whichever requester won.
    always_comb begin
        op_s = '0;
        if (gnt_s[1]) begin
            op_s = '{data: sgnj_apply(req1_sel, req1_a, req1_b), tag: req1_tag, src: 1'b1};
        end else begin
            op_s = '{data: sgnj_apply(req0_sel, req0_a, req0_b), tag: req0_tag, src: 1'b0};
        end
    end

    // Stage register: holds one granted op for exactly one cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stage_valid_r <= 1'b0;
            stage_r       <= '0;
        end else begin
            stage_valid_r <= |gnt_s;
            if (|gnt_s) begin
                stage_r <= op_s;
            end else begin
                stage_r <= stage_r;
            end
        end
    end

    // Result FIFO. Credit gating guarantees room whenever the stage pushes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
            for (int i = 0; i < OUT_DEPTH; i++) begin
                mem_r[i] <= '0;
            end
        end else begin
            if (stage_valid_r) begin
                mem_r[wr_ptr_r] <= stage_r;
                wr_ptr_r        <= wr_ptr_r + PTR_W'(1);
            end else begin
                wr_ptr_r <= wr_ptr_r;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end else begin
                rd_ptr_r <= rd_ptr_r;
            end
            count_r <= count_r + {{(CNT_W-1){1'b0}}, stage_valid_r} - {{(CNT_W-1){1'b0}}, pop_s};
        end
    end

    assign head_s    = mem_r[rd_ptr_r];
    assign res_valid = (count_r != {CNT_W{1'b0}});
    assign res_data  = res_valid ? head_s.data : 16'h0000;
    assign res_tag   = res_valid ? head_s.tag  : {TAG_W{1'b0}};
    assign res_src   = res_valid ? head_s.src  : 1'b0;
    assign busy      = stage_valid_r | res_valid;

endmodule

// File: tb/tb_sgnj_issue_arbiter.sv
// Directed vector table plus hand-written sequences and a random scoreboard
// for the sign-injection issue arbiter.
module tb_sgnj_issue_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        req0_valid, req0_ready, req1_valid, req1_ready;
    logic [1:0]  req0_sel, req1_sel;
    logic [15:0] req0_a, req0_b, req1_a, req1_b;
    logic [3:0]  req0_tag, req1_tag;
    logic        res_valid, res_ready, res_src, busy;
    logic [15:0] res_data;
    logic [3:0]  res_tag;

    int errors = 0;
    int checks = 0;

    sgnj_issue_arbiter #(.TAG_W(4), .OUT_DEPTH(2)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_sel(req0_sel),
        .req0_a(req0_a), .req0_b(req0_b), .req0_tag(req0_tag),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_sel(req1_sel),
        .req1_a(req1_a), .req1_b(req1_b), .req1_tag(req1_tag),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
        .res_tag(res_tag), .res_src(res_src), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        src;
        logic [1:0]  sel;
        logic [15:0] a;
        logic [15:0] b;
        logic [3:0]  tag;
        logic [15:0] exp;
    } vec_t;

    vec_t vecs [8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic idle();
        req0_valid = 1'b0; req1_valid = 1'b0;
        req0_sel = 2'b00; req1_sel = 2'b00;
        req0_a = 16'h0000; req0_b = 16'h0000; req1_a = 16'h0000; req1_b = 16'h0000;
        req0_tag = 4'h0; req1_tag = 4'h0;
    endtask

    task automatic drive(input logic src, input logic [1:0] sel, input logic [15:0] a,
                         input logic [15:0] b, input logic [3:0] tag);
        if (src) begin
            req1_valid = 1'b1; req1_sel = sel; req1_a = a; req1_b = b; req1_tag = tag;
        end else begin
            req0_valid = 1'b1; req0_sel = sel; req0_a = a; req0_b = b; req0_tag = tag;
        end
    endtask

    // Reference: sign bit picked per op, magnitude from a for negate, else from b.
    function automatic logic [15:0] model(input logic [1:0] sel, input logic [15:0] a, input logic [15:0] b);
        logic s;
        logic [14:0] m;
        m = (sel == 2'b00) ? a[14:0] : b[14:0];
        case (sel)
            2'b00:   s = !a[15];
            2'b01:   s = a[15];
            2'b10:   s = !a[15];
            default: s = (a[15] != b[15]);
        endcase
        return {s, m};
    endfunction

    logic [20:0] sb [$];
    logic        order [3];
    int          acc;
    logic        prev_hold;
    logic [20:0] prev_res;
    logic [20:0] exp_res;
    logic [15:0] ra, rb;
    logic [1:0]  rs;

    initial begin
        vecs[0] = '{1'b0, 2'b00, 16'h3C00, 16'h0000, 4'h3, 16'hBC00};
        vecs[1] = '{1'b1, 2'b11, 16'h8000, 16'hC000, 4'h5, 16'h4000};
        vecs[2] = '{1'b1, 2'b10, 16'h0000, 16'h4200, 4'h6, 16'hC200};
        vecs[3] = '{1'b0, 2'b01, 16'h8000, 16'h3C00, 4'h7, 16'hBC00};
        vecs[4] = '{1'b0, 2'b11, 16'h8000, 16'hBC00, 4'h8, 16'h3C00};
        vecs[5] = '{1'b1, 2'b00, 16'hC500, 16'h1234, 4'h9, 16'h4500};
        vecs[6] = '{1'b1, 2'b01, 16'h0123, 16'hFFFF, 4'hA, 16'h7FFF};
        vecs[7] = '{1'b0, 2'b10, 16'hFFFF, 16'h0001, 4'hF, 16'h0001};

        rst = 1'b1;
        idle();
        res_ready = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_res_valid", res_valid, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_data", res_data, 16'h0000);
        check("rst_ready", {req1_ready, req0_ready}, 2'b00);
        rst = 1'b0;

        // Single ops: grant on edge k, result visible after edge k+1.
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            drive(vecs[i].src, vecs[i].sel, vecs[i].a, vecs[i].b, vecs[i].tag);
            #1;
            check($sformatf("v%0d_ready", i), {req1_ready, req0_ready},
                  vecs[i].src ? 2'b10 : 2'b01);
            @(negedge clk);
            idle();
            #1;
            check($sformatf("v%0d_lat", i), res_valid, 1'b0);
            check($sformatf("v%0d_busy", i), busy, 1'b1);
            @(negedge clk);
            #1;
            check($sformatf("v%0d_valid", i), res_valid, 1'b1);
            check($sformatf("v%0d_data", i), res_data, vecs[i].exp);
            check($sformatf("v%0d_tag", i), res_tag, vecs[i].tag);
            check($sformatf("v%0d_src", i), res_src, vecs[i].src);
        end
        @(negedge clk);
        #1;
        check("drain_idle", {res_valid, busy}, 2'b00);

        // Reset with stage full and one FIFO entry.
        res_ready = 1'b0;
        drive(1'b0, 2'b00, 16'h0001, 16'h0000, 4'h1);
        @(negedge clk);
        drive(1'b0, 2'b00, 16'h0002, 16'h0000, 4'h2);
        @(negedge clk);
        #1;
        check("pre_rst_valid", res_valid, 1'b1);
        rst = 1'b1;
        #1;
        check("mid_rst_valid", res_valid, 1'b0);
        check("mid_rst_busy", busy, 1'b0);
        check("mid_rst_ready", {req1_ready, req0_ready}, 2'b00);
        check("mid_rst_out", {res_data, res_tag, res_src}, 21'h0);
        @(negedge clk);
        rst = 1'b0;
        idle();
        res_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1;
            check("no_stale", {res_valid, busy}, 2'b00);
        end

        // Continuous conflict: req0 first, then alternation at one result per cycle.
        drive(1'b0, 2'b00, 16'h1000, 16'h0000, 4'h1);
        drive(1'b1, 2'b00, 16'h9000, 16'h0000, 4'h2);
        for (int n = 0; n < 10; n++) begin
            #1;
            check($sformatf("alt%0d_ready", n), {req1_ready, req0_ready}, (n % 2 == 0) ? 2'b01 : 2'b10);
            if (n >= 2) begin
                check($sformatf("alt%0d_res", n), {res_valid, res_src, res_tag},
                      (n % 2 == 0) ? 6'b10_0001 : 6'b11_0010);
            end
            @(negedge clk);
        end
        idle();
        repeat (4) @(negedge clk);
        #1;
        check("alt_drain", busy, 1'b0);

        // Backpressure: exactly OUT_DEPTH accepts, then resume on the first pop.
        res_ready = 1'b0;
        drive(1'b0, 2'b00, 16'h1111, 16'h0000, 4'hA);
        drive(1'b1, 2'b00, 16'h2222, 16'h0000, 4'hB);
        acc = 0;
        for (int i = 0; i < 6; i++) begin
            #1;
            if (req0_ready && req1_ready) check("bp_both_ready", 1'b1, 1'b0);
            if ((req0_ready || req1_ready) && acc < 2) order[acc] = req1_ready;
            if (req0_ready || req1_ready) acc++;
            @(negedge clk);
        end
        check("bp_accepts", acc, 2);
        check("bp_rr", order[1], !order[0]);
        res_ready = 1'b1;
        #1;
        check("bp_resume", req0_ready | req1_ready, 1'b1);
        order[2] = req1_ready;
        check("bp_head0", {res_valid, res_src, res_tag, res_data},
              order[0] ? {2'b11, 4'hB, 16'hA222} : {2'b10, 4'hA, 16'h9111});
        @(negedge clk);
        idle();
        #1;
        check("bp_head1", {res_valid, res_src, res_tag},
              order[1] ? {2'b11, 4'hB} : {2'b10, 4'hA});
        @(negedge clk);
        #1;
        check("bp_head2", {res_valid, res_src, res_tag},
              order[2] ? {2'b11, 4'hB} : {2'b10, 4'hA});
        repeat (3) @(negedge clk);
        #1;
        check("bp_drain", busy, 1'b0);

        // Random traffic against a scoreboard.
        prev_hold = 1'b0;
        prev_res  = '0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            @(negedge clk);
            idle();
            if (cyc < 300) begin
                if ($urandom_range(0, 2) != 0) begin
                    ra = 16'($urandom); rb = 16'($urandom); rs = 2'($urandom);
                    drive(1'b0, rs, ra, rb, 4'($urandom));
                end
                if ($urandom_range(0, 2) != 0) begin
                    ra = 16'($urandom); rb = 16'($urandom); rs = 2'($urandom);
                    drive(1'b1, rs, ra, rb, 4'($urandom));
                end
                res_ready = ($urandom_range(0, 3) != 0);
            end else begin
                res_ready = 1'b1;
            end
            #1;
            if (prev_hold) check("rnd_hold", {res_src, res_tag, res_data}, prev_res);
            if (req0_ready && req1_ready) check("rnd_both_ready", 1'b1, 1'b0);
            if (res_valid && res_ready) begin
                if (sb.size() == 0) begin
                    check("rnd_unexpected", 1'b1, 1'b0);
                end else begin
                    exp_res = sb.pop_front();
                    check("rnd_result", {res_src, res_tag, res_data}, exp_res);
                end
            end
            if (req0_valid && req0_ready) sb.push_back({1'b0, req0_tag, model(req0_sel, req0_a, req0_b)});
            if (req1_valid && req1_ready) sb.push_back({1'b1, req1_tag, model(req1_sel, req1_a, req1_b)});
            prev_hold = res_valid && !res_ready;
            prev_res  = {res_src, res_tag, res_data};
        end
        check("rnd_sb_empty", sb.size(), 0);
        check("rnd_busy", busy, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
